// File: rtl/tx_fifo_pkg.sv
// Shared defaults and pointer sizing for the UART transmit FIFO.
package tx_fifo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AFULL_THR = DEF_DEPTH - 2;

  // Address bits plus one wrap bit, so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tx_fifo_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
module tx_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tx_fifo_param.sv
// First-word-fall-through transmit FIFO with occupancy count, status flags
// and a sticky overflow flag.
module tx_fifo_param
  import tx_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_THR = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     rd_ready,
  input  logic                     flush,
  input  logic                     clear_err,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ptr_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q,  count_d;
  logic             overflow_q, overflow_d;
  logic             wr_en, rd_en;

  assign full        = (count_q == PTR_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= PTR_W'(AFULL_THR));
  assign wr_ready    = !full;
  assign rd_valid    = !empty;
  assign count       = count_q;
  assign overflow    = overflow_q;

  // Flush and reset both block the memory write so nothing lands in the array.
  assign wr_en = wr_valid && wr_ready && !flush && !reset;
  assign rd_en = rd_valid && rd_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q && !clear_err;
    if (wr_valid && !wr_ready && !flush) overflow_d = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  tx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_tx_fifo_param.sv
// Randomized and directed bench for tx_fifo_param against a queue model.
module tb_tx_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AFT    = DEPTH - 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset, wr_valid, rd_ready, flush, clear_err;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready, rd_valid, full, empty, almost_full, overflow;
  logic [DATA_W-1:0] rd_data;
  logic [CW-1:0]     count;

  tx_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .flush(flush), .clear_err(clear_err),
    .full(full), .empty(empty), .almost_full(almost_full),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  logic [DATA_W-1:0] mq[$];
  bit                m_ovf = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue updated from the sampled inputs at each edge.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      bit was_full;
      was_full = (mq.size() == DEPTH);
      m_ovf = (wr_valid && was_full && !flush) || (m_ovf && !clear_err);
      if (flush) mq.delete();
      else begin
        bit do_rd, do_wr;
        do_rd = rd_ready && mq.size() > 0;
        do_wr = wr_valid && !was_full;
        if (do_rd) void'(mq.pop_front());
        if (do_wr) mq.push_back(wr_data);
      end
    end
  end

  // Outputs depend only on registered state, so the falling edge is a safe sample point.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",       32'(count),       32'(mq.size()));
      chk("empty",       32'(empty),       32'(mq.size() == 0));
      chk("full",        32'(full),        32'(mq.size() == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFT));
      chk("wr_ready",    32'(wr_ready),    32'(mq.size() != DEPTH));
      chk("rd_valid",    32'(rd_valid),    32'(mq.size() != 0));
      chk("overflow",    32'(overflow),    32'(m_ovf));
      if (mq.size() > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
    end
  end

  task automatic cyc(input logic wv, input logic [7:0] wd, input logic rr,
                     input logic fl = 0, input logic ce = 0, input logic rs = 0);
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl; clear_err = ce; reset = rs;
    @(posedge clk); #1;
    wr_valid = 0; rd_ready = 0; flush = 0; clear_err = 0; reset = 0;
  endtask

  initial begin
    logic [7:0] v;
    wr_valid = 0; wr_data = 0; rd_ready = 0; flush = 0; clear_err = 0; reset = 1;
    @(posedge clk); #1;
    chk_en = 1;
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_count", 32'(count), 0);

    // Fill with 0x11..0x88; almost_full from count 6.
    for (int i = 0; i < 8; i++) begin
      v = 8'((i + 1) * 8'h11);
      cyc(1, v, 0);
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 6));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 8);
    chk("fill_wr_ready", 32'(wr_ready), 0);

    cyc(1, 8'h99, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 32'(rd_data), 32'((i + 1) * 8'h11));
      cyc(0, 0, 1);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("ovf_sticky", 32'(overflow), 1);
    cyc(0, 0, 0, 0, 1);
    chk("ovf_clear", 32'(overflow), 0);

    // Five entries, then 20 cycles of simultaneous read and write.
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 20; i++) begin
      chk("rw_data", 32'(rd_data), 32'(8'h20 + i));
      cyc(1, 8'(8'h25 + i), 1);
    end
    chk("rw_count", 32'(count), 5);

    // Down to three, then flush alongside a write and a read.
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(1, 8'hEE, 1, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    cyc(1, 8'h5A, 0);
    chk("post_flush", 32'(rd_data), 8'h5A);
    cyc(0, 0, 1);

    // Reset mid-burst at count 4 with overflow pending.
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);
    chk("mid_count", 32'(count), 4);
    chk("mid_ovf", 32'(overflow), 1);
    cyc(1, 8'h77, 1, 0, 0, 1);
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_empty", 32'(empty), 1);
    chk("rst_mid_ovf", 32'(overflow), 0);
    cyc(1, 8'h3C, 0);
    chk("rst_first_wr", 32'(rd_data), 8'h3C);
    cyc(0, 0, 1);

    // Empty write of 0xA5 is visible one edge later.
    cyc(1, 8'hA5, 0);
    chk("a5_valid", 32'(rd_valid), 1);
    chk("a5_data", 32'(rd_data), 8'hA5);
    for (int i = 0; i < 7; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'hFF, 0, 0, 1);
    chk("set_wins", 32'(overflow), 1);
    cyc(0, 0, 0, 0, 1);
    chk("clr_only", 32'(overflow), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1,
          $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 199) == 0);
    end

    @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
